// File: rtl/register_file_reader.sv
// rtl/register_file_reader.sv - architectural register file with busy scoreboard and bypassed registered reads
// Two registered operand reads, one write-back port, per-register busy bits that stall decode.
module register_file_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic                  issueDestValid,
    input  logic [ADDR_WIDTH-1:0] issueDest,
    input  logic [1:0]            writeBackControl,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  stall,
    output logic                  readValid,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic                  wb_any;
    logic                  wb_en;
    logic                  wb_hit1;
    logic                  wb_hit2;
    logic                  op1_ready;
    logic                  op2_ready;
    logic                  accept;
    logic                  issue_set;
    logic [DATA_WIDTH-1:0] rd1_next;
    logic [DATA_WIDTH-1:0] rd2_next;

    // memToReg only matters upstream of the write-back mux
    logic unused_mem_to_reg;
    assign unused_mem_to_reg = writeBackControl[0];

    always_comb begin
        wb_any    = writeBackControl[1];
        wb_en     = wb_any && (writeReg != '0);
        wb_hit1   = wb_any && (writeReg == readReg1);
        wb_hit2   = wb_any && (writeReg == readReg2);
        op1_ready = (readReg1 == '0) || !busy[readReg1] || wb_hit1;
        op2_ready = (readReg2 == '0) || !busy[readReg2] || wb_hit2;
        stall     = readEnable && !(op1_ready && op2_ready);
        accept    = readEnable && !stall;
        issue_set = accept && issueDestValid && (issueDest != '0);
        // Register 0 is hard-wired to zero, so a write-back to it is never forwarded
        rd1_next  = (wb_hit1 && readReg1 != '0) ? writeData : regs[readReg1];
        rd2_next  = (wb_hit2 && readReg2 != '0) ? writeData : regs[readReg2];
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            readValid <= 1'b0;
            readData1 <= '0;
            readData2 <= '0;
        end else begin
            if (wb_en) begin
                regs[writeReg] <= writeData;
                busy[writeReg] <= 1'b0;
            end
            // Issued later in program order than the retiring write, so the set must win
            if (issue_set) begin
                busy[issueDest] <= 1'b1;
            end
            readValid <= accept;
            if (accept) begin
                readData1 <= rd1_next;
                readData2 <= rd2_next;
            end
        end
    end

endmodule

// File: tb/tb_register_file_reader.sv
// tb/tb_register_file_reader.sv - directed vector bench for register_file_reader
module tb_register_file_reader;

    logic        clk = 1'b0;
    logic        resetN;
    logic        readEnable;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        issueDestValid;
    logic [4:0]  issueDest;
    logic [1:0]  writeBackControl;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        stall;
    logic        readValid;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int checks = 0;
    int errors = 0;

    register_file_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk),
        .resetN(resetN),
        .readEnable(readEnable),
        .readReg1(readReg1),
        .readReg2(readReg2),
        .issueDestValid(issueDestValid),
        .issueDest(issueDest),
        .writeBackControl(writeBackControl),
        .writeReg(writeReg),
        .writeData(writeData),
        .stall(stall),
        .readValid(readValid),
        .readData1(readData1),
        .readData2(readData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        re;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        idv;
        logic [4:0]  idest;
        logic [1:0]  wbc;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic re, input logic [4:0] r1, input logic [4:0] r2,
                         input logic idv, input logic [4:0] idest, input logic [1:0] wbc,
                         input logic [4:0] wreg, input logic [31:0] wdata);
        @(negedge clk);
        resetN           = rst_n;
        readEnable       = re;
        readReg1         = r1;
        readReg2         = r2;
        issueDestValid   = idv;
        issueDest        = idest;
        writeBackControl = wbc;
        writeReg         = wreg;
        writeData        = wdata;
        #1;
    endtask

    function automatic vec_t mk(input logic rst_n, input logic re, input logic [4:0] r1, input logic [4:0] r2,
                                input logic idv, input logic [4:0] idest, input logic [1:0] wbc,
                                input logic [4:0] wreg, input logic [31:0] wdata,
                                input logic es, input logic ev, input logic [31:0] d1, input logic [31:0] d2);
        vec_t v;
        v.rst_n = rst_n; v.re = re; v.r1 = r1; v.r2 = r2; v.idv = idv; v.idest = idest;
        v.wbc = wbc; v.wreg = wreg; v.wdata = wdata;
        v.exp_stall = es; v.exp_valid = ev; v.exp_d1 = d1; v.exp_d2 = d2;
        return v;
    endfunction

    initial begin
        int waited;

        resetN = 1'b0; readEnable = 1'b0; readReg1 = '0; readReg2 = '0;
        issueDestValid = 1'b0; issueDest = '0; writeBackControl = '0; writeReg = '0; writeData = '0;

        //            rst re r1  r2  idv dst wbc    wreg wdata          stall valid d1             d2
        vecs[0]  = mk(0, 0, 0,  0,  0, 0,  2'b00, 0,  32'h0,          0, 0, 32'h0,          32'h0);
        vecs[1]  = mk(1, 1, 1,  2,  0, 0,  2'b00, 0,  32'h0,          0, 1, 32'h0,          32'h0);
        vecs[2]  = mk(1, 0, 0,  0,  0, 0,  2'b10, 5,  32'hDEADBEEF,   0, 0, 32'h0,          32'h0);
        vecs[3]  = mk(1, 1, 5,  0,  0, 0,  2'b00, 0,  32'h0,          0, 1, 32'hDEADBEEF,   32'h0);
        vecs[4]  = mk(1, 0, 0,  0,  0, 0,  2'b11, 0,  32'h12345678,   0, 0, 32'hDEADBEEF,   32'h0);
        vecs[5]  = mk(1, 1, 0,  0,  0, 0,  2'b00, 0,  32'h0,          0, 1, 32'h0,          32'h0);
        vecs[6]  = mk(1, 1, 1,  2,  1, 3,  2'b00, 0,  32'h0,          0, 1, 32'h0,          32'h0);
        vecs[7]  = mk(1, 1, 3,  1,  0, 0,  2'b00, 0,  32'h0,          1, 0, 32'h0,          32'h0);
        vecs[8]  = mk(1, 1, 3,  1,  0, 0,  2'b00, 0,  32'h0,          1, 0, 32'h0,          32'h0);
        vecs[9]  = mk(1, 1, 3,  1,  0, 0,  2'b10, 3,  32'h0000A5A5,   0, 1, 32'h0000A5A5,   32'h0);
        vecs[10] = mk(1, 1, 3,  3,  0, 0,  2'b00, 0,  32'h0,          0, 1, 32'h0000A5A5,   32'h0000A5A5);
        vecs[11] = mk(1, 1, 1,  2,  1, 7,  2'b10, 7,  32'h00000077,   0, 1, 32'h0,          32'h0);
        vecs[12] = mk(1, 1, 7,  0,  0, 0,  2'b00, 0,  32'h0,          1, 0, 32'h0,          32'h0);
        vecs[13] = mk(1, 1, 7,  0,  0, 0,  2'b10, 7,  32'h00000099,   0, 1, 32'h00000099,   32'h0);
        vecs[14] = mk(1, 1, 1,  2,  1, 0,  2'b00, 0,  32'h0,          0, 1, 32'h0,          32'h0);
        vecs[15] = mk(1, 1, 0,  0,  0, 0,  2'b00, 0,  32'h0,          0, 1, 32'h0,          32'h0);
        vecs[16] = mk(1, 1, 5,  5,  1, 4,  2'b00, 0,  32'h0,          0, 1, 32'hDEADBEEF,   32'hDEADBEEF);
        vecs[17] = mk(1, 1, 2,  4,  0, 0,  2'b00, 0,  32'h0,          1, 0, 32'hDEADBEEF,   32'hDEADBEEF);
        vecs[18] = mk(0, 1, 2,  4,  0, 0,  2'b00, 0,  32'h0,          1, 0, 32'h0,          32'h0);
        vecs[19] = mk(1, 1, 4,  5,  0, 0,  2'b00, 0,  32'h0,          0, 1, 32'h0,          32'h0);
        vecs[20] = mk(1, 1, 0,  5,  0, 0,  2'b10, 0,  32'hFFFFFFFF,   0, 1, 32'h0,          32'h0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst_n, vecs[i].re, vecs[i].r1, vecs[i].r2, vecs[i].idv, vecs[i].idest,
                  vecs[i].wbc, vecs[i].wreg, vecs[i].wdata);
            check("stall", i, {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            @(posedge clk);
            #1;
            check("readValid", i, {31'b0, readValid}, {31'b0, vecs[i].exp_valid});
            check("readData1", i, readData1, vecs[i].exp_d1);
            check("readData2", i, readData2, vecs[i].exp_d2);
        end

        // Long stall on r9 released by a bypassed write-back
        drive(1, 1, 1, 2, 1, 9, 2'b00, 0, 32'h0);
        check("issue_r9_stall", 100, {31'b0, stall}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 9, 9, 0, 0, 2'b00, 0, 32'h0);
            check("r9_held_stall", 101 + k, {31'b0, stall}, 32'h1);
            @(posedge clk);
            #1;
            check("r9_held_valid", 101 + k, {31'b0, readValid}, 32'h0);
        end
        drive(1, 1, 9, 9, 0, 0, 2'b10, 9, 32'hCAFEF00D);
        check("r9_release_stall", 104, {31'b0, stall}, 32'h0);
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!readValid && waited < 4);
        check("r9_valid_in_one", 105, waited, 1);
        check("r9_bypass_d1", 105, readData1, 32'hCAFEF00D);
        check("r9_bypass_d2", 105, readData2, 32'hCAFEF00D);

        drive(1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0);
        @(posedge clk);
        #1;
        check("idle_valid", 106, {31'b0, readValid}, 32'h0);
        check("idle_hold_d1", 106, readData1, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
